// File: rtl/brisc_pkg.sv
// Shared definitions for the BRISC operand path: select codes and immediate extension.
package brisc_pkg;

    localparam int SEL_W = 3;
    localparam int EXT_W = 64;

    localparam logic [SEL_W-1:0] SEL_REG    = 3'd0;
    localparam logic [SEL_W-1:0] SEL_IMM_Z  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_PC     = 3'd2;
    localparam logic [SEL_W-1:0] SEL_IMM_S  = 3'd3;
    localparam logic [SEL_W-1:0] SEL_IMM_HI = 3'd4;
    localparam logic [SEL_W-1:0] SEL_FWD    = 3'd5;

    // Extends the low imm_w bits of imm to EXT_W; callers truncate to their datapath width.
    function automatic logic [EXT_W-1:0] ext_imm(input logic [EXT_W-1:0] imm,
                                                 input int imm_w,
                                                 input logic sign);
        logic [EXT_W-1:0] low_mask;
        logic [EXT_W-1:0] msb;
        low_mask = (EXT_W'(1) << imm_w) - EXT_W'(1);
        msb      = EXT_W'(1) << (imm_w - 1);
        if (sign && ((imm & msb) != '0))
            return (imm & low_mask) | ~low_mask;
        return imm & low_mask;
    endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Upstream/downstream handshake bundle of the operand-B stage.
interface operand_stage_if
    import brisc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8,
    parameter int PC_W   = 8,
    parameter int TAG_W  = 4
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  imm_ctl;
    logic [DATA_W-1:0] reg_data;
    logic [IMM_W-1:0]  immediate;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] fwd_data;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_to_alu;
    logic [TAG_W-1:0]  out_tag;
    logic              sel_err;

    modport master (
        output flush, in_valid, imm_ctl, reg_data, immediate, pc, fwd_data, in_tag, out_ready,
        input  in_ready, out_valid, data_to_alu, out_tag, sel_err
    );

    modport slave (
        input  flush, in_valid, imm_ctl, reg_data, immediate, pc, fwd_data, in_tag, out_ready,
        output in_ready, out_valid, data_to_alu, out_tag, sel_err
    );
endinterface

// File: rtl/operand_stage_skid_buffer.sv
// Two-entry valid/ready slot: M drives the outputs, S catches the one entry accepted under stall.
//  state | meaning
//  EMPTY | M and S empty, ready to accept
//  ONE   | M holds the output entry, S empty
//  FULL  | M and S both hold entries, in_ready low
module skid_buffer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t       state;
    logic [W-1:0] s_data;
    logic         accept;
    logic         xfer;

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            s_data    <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                    state     <= ONE;
                end
                ONE: begin
                    if (accept && xfer) begin
                        out_data <= in_data;
                    end else if (accept) begin
                        s_data   <= in_data;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                // in_ready is low here, so the only move is S sliding into M
                FULL: if (xfer) begin
                    out_data <= s_data;
                    in_ready <= 1'b1;
                    state    <= ONE;
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/operand_stage.sv
// Operand-B select for the BRISC ALU, registered through a two-entry skid slot.
module operand_stage
    import brisc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8,
    parameter int PC_W   = 8,
    parameter int TAG_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    operand_stage_if.slave  bus
);
    localparam int PAY_W = DATA_W + TAG_W;

    logic [DATA_W-1:0] imm_z;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] imm_hi;
    logic [DATA_W-1:0] sel_data;
    logic [PAY_W-1:0]  out_pay;
    logic              accept;

    assign imm_z  = DATA_W'(ext_imm(EXT_W'(bus.immediate), IMM_W, 1'b0));
    assign imm_s  = DATA_W'(ext_imm(EXT_W'(bus.immediate), IMM_W, 1'b1));
    assign imm_hi = DATA_W'(bus.immediate) << (DATA_W - IMM_W);

    always_comb begin
        sel_data = bus.reg_data;
        case (bus.imm_ctl)
            SEL_REG:    sel_data = bus.reg_data;
            SEL_IMM_Z:  sel_data = imm_z;
            SEL_PC:     sel_data = DATA_W'(bus.pc);
            SEL_IMM_S:  sel_data = imm_s;
            SEL_IMM_HI: sel_data = imm_hi;
            SEL_FWD:    sel_data = bus.fwd_data;
            default:    sel_data = bus.reg_data;
        endcase
    end

    assign accept = bus.in_valid && bus.in_ready;

    // Sticky on any accepted reserved code, even one dropped by a same-cycle flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.sel_err <= 1'b0;
        else if (accept && (bus.imm_ctl > SEL_FWD))
            bus.sel_err <= 1'b1;
    end

    skid_buffer #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({bus.in_tag, sel_data}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_pay)
    );

    assign {bus.out_tag, bus.data_to_alu} = out_pay;
endmodule

// File: tb/tb_operand_stage.sv
// Checks operand_stage against a queue-based model of a two-deep FIFO with operand selection.
module tb_operand_stage;
    localparam int DATA_W = 16;
    localparam int IMM_W  = 8;
    localparam int PC_W   = 8;
    localparam int TAG_W  = 4;
    localparam int PAY_W  = DATA_W + TAG_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_stage_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .PC_W(PC_W), .TAG_W(TAG_W)) bus ();

    operand_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .PC_W(PC_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [PAY_W-1:0] mq[$];
    bit  m_err;
    bit  last_acc;
    int  n_cmp;
    int  n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_op(input int ctl, input int rd, input int imm,
                                                 input int pcv, input int fwd);
        longint v;
        case (ctl)
            1:       v = imm;
            2:       v = pcv;
            3:       v = (imm >= 2**(IMM_W-1)) ? imm - 2**IMM_W : imm;
            4:       v = longint'(imm) * 2**(DATA_W-IMM_W);
            5:       v = fwd;
            default: v = rd;
        endcase
        if (v < 0) v = v + 2**DATA_W;
        return DATA_W'(v % 2**DATA_W);
    endfunction

    task automatic drive(input bit vld, input int ctl, input int rd, input int imm,
                         input int pcv, input int fwd, input int tag);
        bus.in_valid  = vld;
        bus.imm_ctl   = 3'(ctl);
        bus.reg_data  = DATA_W'(rd);
        bus.immediate = IMM_W'(imm);
        bus.pc        = PC_W'(pcv);
        bus.fwd_data  = DATA_W'(fwd);
        bus.in_tag    = TAG_W'(tag);
    endtask

    task automatic check_state();
        logic [PAY_W-1:0] head;
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
        chk("sel_err", 32'(bus.sel_err), 32'(m_err));
        if (mq.size() > 0) begin
            head = mq[0];
            chk("data_to_alu", 32'(bus.data_to_alu), 32'(head[DATA_W-1:0]));
            chk("out_tag", 32'(bus.out_tag), 32'(head[PAY_W-1:DATA_W]));
        end
    endtask

    task automatic tick();
        bit acc, xf;
        logic [PAY_W-1:0] ent;
        acc = bus.in_valid && (mq.size() < 2);
        xf  = (mq.size() > 0) && bus.out_ready;
        ent = {bus.in_tag, ref_op(int'(bus.imm_ctl), int'(bus.reg_data), int'(bus.immediate),
                                  int'(bus.pc), int'(bus.fwd_data))};
        @(posedge clk);
        if (acc && bus.imm_ctl >= 3'd6) m_err = 1'b1;
        if (bus.flush) mq.delete();
        else begin
            if (xf) void'(mq.pop_front());
            if (acc) mq.push_back(ent);
        end
        last_acc = acc;
        #1;
        check_state();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        mq.delete();
        m_err = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    int stream_cnt;

    initial begin
        n_cmp = 0; n_bad = 0; m_err = 1'b0; last_acc = 1'b0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_data", 32'(bus.data_to_alu), 32'd0);
        chk("rst_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_sel_err", 32'(bus.sel_err), 32'd0);
        rst_n = 1'b1;

        // extension and select codes
        bus.out_ready = 1'b1;
        drive(1, 3, 16'h1111, 8'h80, 0, 0, 1); tick();
        chk("imm_s", 32'(bus.data_to_alu), 32'h0000FF80);
        drive(1, 1, 16'h1111, 8'h80, 0, 0, 2); tick();
        chk("imm_z", 32'(bus.data_to_alu), 32'h00000080);
        drive(1, 4, 0, 8'h12, 0, 0, 3); tick();
        chk("imm_hi", 32'(bus.data_to_alu), 32'h00001200);
        drive(1, 2, 0, 0, 8'hA5, 0, 4); tick();
        chk("pc", 32'(bus.data_to_alu), 32'h000000A5);
        drive(1, 5, 0, 0, 0, 16'hBEEF, 5); tick();
        chk("fwd", 32'(bus.data_to_alu), 32'h0000BEEF);
        drive(0, 0, 0, 0, 0, 0, 0); tick();

        // backpressure: third entry held until S drains
        bus.out_ready = 1'b0;
        drive(1, 0, 16'h0101, 0, 0, 0, 1); tick();
        drive(1, 0, 16'h0202, 0, 0, 0, 2); tick();
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1, 0, 16'h0303, 0, 0, 0, 3); tick(); tick();
        chk("bp_head_tag", 32'(bus.out_tag), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_tag2", 32'(bus.out_tag), 32'd2);
        tick();
        chk("bp_tag3", 32'(bus.out_tag), 32'd3);
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        chk("bp_drained", 32'(bus.out_valid), 32'd0);

        // streaming
        stream_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 5, 0, 0, 0, 16'hA000 + i, i); tick();
            if (bus.out_valid && bus.in_ready) stream_cnt++;
        end
        chk("stream_cnt", 32'(stream_cnt), 32'd10);
        drive(0, 0, 0, 0, 0, 0, 0); tick();

        // flush from FULL with an entry offered
        bus.out_ready = 1'b0;
        drive(1, 0, 16'h0A0A, 0, 0, 0, 10); tick();
        drive(1, 0, 16'h0B0B, 0, 0, 0, 11); tick();
        drive(1, 0, 16'h0C0C, 0, 0, 0, 9);
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1; tick(); tick();

        // reserved code
        drive(1, 6, 16'h1234, 8'hFF, 0, 16'hFFFF, 7); tick();
        chk("rsv_data", 32'(bus.data_to_alu), 32'h00001234);
        chk("rsv_err", 32'(bus.sel_err), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        chk("err_after_flush", 32'(bus.sel_err), 32'd1);
        do_reset();

        // randomized traffic with a mid-stream asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            if (!(bus.in_valid && !last_acc))
                drive($urandom_range(99) < 70, $urandom_range(7), $urandom, $urandom,
                      $urandom, $urandom, $urandom);
            bus.out_ready = $urandom_range(99) < 60;
            bus.flush = $urandom_range(99) < 3;
            tick();
            if (i == 1500) begin
                #1 rst_n = 1'b0;
                #1;
                chk("async_out_valid", 32'(bus.out_valid), 32'd0);
                chk("async_in_ready", 32'(bus.in_ready), 32'd1);
                chk("async_data", 32'(bus.data_to_alu), 32'd0);
                chk("async_tag", 32'(bus.out_tag), 32'd0);
                chk("async_sel_err", 32'(bus.sel_err), 32'd0);
                mq.delete();
                m_err = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        bus.flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
